// File: rtl/contrast_adjust_pkg.sv
// contrast_pkg: shared constants, the clamp result type and the per-channel
// contrast arithmetic used by contrast_adjust.
package contrast_pkg;

  localparam int DATA_W = 8;
  localparam int LVL_W  = 4;
  localparam int D_W    = 9;
  localparam int P_W    = 13;
  localparam int MID    = 128;
  localparam int SHIFT  = 3;

  localparam logic [LVL_W-1:0] LEVEL_DEFAULT = 4'd8;
  localparam logic [LVL_W-1:0] LEVEL_MAX     = 4'd15;

  typedef struct packed {
    logic [DATA_W-1:0] pix;
    logic              clip;
  } clamp_t;

  // Centre the pixel on mid-grey and scale by the level (level 8 == gain 1.0).
  function automatic logic signed [P_W-1:0] contrast_mult(
    input logic [DATA_W-1:0] pix,
    input logic [LVL_W-1:0]  lvl
  );
    logic signed [D_W-1:0] d;
    logic signed [P_W-1:0] dx;
    logic signed [P_W-1:0] lx;
    d  = {1'b0, pix} - 9'd128;
    dx = {{(P_W-D_W){d[D_W-1]}}, d};
    lx = {{(P_W-LVL_W){1'b0}}, lvl};
    return dx * lx;
  endfunction

  // Divide by 8 (floor), restore the mid-grey offset and clamp to 8 bits.
  function automatic clamp_t contrast_clamp(input logic signed [P_W-1:0] p);
    logic signed [P_W-1:0] s;
    logic signed [P_W-1:0] y;
    clamp_t r;
    s = p >>> SHIFT;
    y = s + P_W'(MID);
    if (y[P_W-1]) begin
      r.pix  = '0;
      r.clip = 1'b1;
    end else if (y > P_W'(255)) begin
      r.pix  = '1;
      r.clip = 1'b1;
    end else begin
      r.pix  = y[DATA_W-1:0];
      r.clip = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/contrast_adjust_key_edge.sv
// key_edge: two-flop synchroniser for one active-low push key, producing a
// single-cycle pulse on the synchronised high-to-low transition.
module key_edge (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  logic sync_p0;
  logic sync_p1;
  logic sync_p2;

  // Synchroniser chain plus one delayed copy for edge detection; released (high) in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      sync_p2 <= 1'b1;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign press = sync_p2 & ~sync_p1;

endmodule

// File: rtl/contrast_adjust.sv
// contrast_adjust: per-channel contrast scaling around mid-grey with a
// 2-cycle pipeline. Keys adjust a pending level that becomes active only at
// the start of a frame. Optional feature macro CONTRAST_CLIP_CNT_EN adds a
// per-frame clipped-pixel counter on the clip_count port.
module contrast_adjust
  import contrast_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ri,
  input  logic [DATA_W-1:0] gi,
  input  logic [DATA_W-1:0] bi,
  input  logic              in_valid,
  input  logic              vsync,
  input  logic [1:0]        ctrl,
  output logic [DATA_W-1:0] ro,
  output logic [DATA_W-1:0] go,
  output logic [DATA_W-1:0] bo,
  output logic              out_valid,
  output logic [LVL_W-1:0]  level
`ifdef CONTRAST_CLIP_CNT_EN
  ,
  output logic [15:0]       clip_count
`endif
);

  logic             up_evt;
  logic             dn_evt;
  logic             vsync_q;
  logic             vsync_rise;
  logic [LVL_W-1:0] pend_level;

  key_edge u_key_up (.clk(clk), .reset(reset), .key_n(ctrl[1]), .press(up_evt));
  key_edge u_key_dn (.clk(clk), .reset(reset), .key_n(ctrl[0]), .press(dn_evt));

  assign vsync_rise = vsync & ~vsync_q;

  // Pending level tracks key events with saturation; active level only loads at frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_level <= LEVEL_DEFAULT;
      level      <= LEVEL_DEFAULT;
      vsync_q    <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (up_evt && !dn_evt && pend_level != LEVEL_MAX)
        pend_level <= pend_level + 4'd1;
      else if (dn_evt && !up_evt && pend_level != '0)
        pend_level <= pend_level - 4'd1;
      if (vsync_rise)
        level <= pend_level;
    end
  end

  // ---- stage 1: scaled products ----
  logic signed [P_W-1:0] prod_r_p1;
  logic signed [P_W-1:0] prod_g_p1;
  logic signed [P_W-1:0] prod_b_p1;
  logic                  vld_p1;

  // Stage 1 qualifier; cleared in reset so in-flight pixels are discarded.
  always_ff @(posedge clk) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= in_valid;
  end

  // Stage 1 data advances every cycle using the currently active level.
  always_ff @(posedge clk) begin
    prod_r_p1 <= contrast_mult(ri, level);
    prod_g_p1 <= contrast_mult(gi, level);
    prod_b_p1 <= contrast_mult(bi, level);
  end

  // ---- stage 2: shift, offset, clamp ----
  clamp_t clamp_r;
  clamp_t clamp_g;
  clamp_t clamp_b;

  assign clamp_r = contrast_clamp(prod_r_p1);
  assign clamp_g = contrast_clamp(prod_g_p1);
  assign clamp_b = contrast_clamp(prod_b_p1);

  // Registered outputs; cleared in reset so the output pins read zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      ro        <= '0;
      go        <= '0;
      bo        <= '0;
      out_valid <= 1'b0;
    end else begin
      ro        <= clamp_r.pix;
      go        <= clamp_g.pix;
      bo        <= clamp_b.pix;
      out_valid <= vld_p1;
    end
  end

`ifdef CONTRAST_CLIP_CNT_EN
  logic [15:0] clip_acc;
  logic        clip_hit;

  assign clip_hit = vld_p1 & (clamp_r.clip | clamp_g.clip | clamp_b.clip);

  // Per-frame clip counter; a clip coinciding with frame start belongs to the new frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      clip_acc   <= '0;
      clip_count <= '0;
    end else if (vsync_rise) begin
      clip_count <= clip_acc;
      clip_acc   <= {15'd0, clip_hit};
    end else if (clip_hit && clip_acc != 16'hFFFF) begin
      clip_acc <= clip_acc + 16'd1;
    end
  end
`else
  logic clip_unused;
  assign clip_unused = clamp_r.clip ^ clamp_g.clip ^ clamp_b.clip;
`endif

endmodule

// File: tb/tb_contrast_adjust.sv
// tb_contrast_adjust: randomized scoreboard bench for contrast_adjust with a
// behavioural reference model of keys, frame-start level loads and the
// per-channel contrast formula.
module tb_contrast_adjust;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  ri = '0, gi = '0, bi = '0;
  logic        in_valid = 1'b0;
  logic        vsync = 1'b0;
  logic [1:0]  ctrl = 2'b11;
  logic [7:0]  ro, go, bo;
  logic        out_valid;
  logic [3:0]  level;
`ifdef CONTRAST_CLIP_CNT_EN
  logic [15:0] clip_count;
`endif

  contrast_adjust dut (
    .clk(clk), .reset(reset), .ri(ri), .gi(gi), .bi(bi),
    .in_valid(in_valid), .vsync(vsync), .ctrl(ctrl),
    .ro(ro), .go(go), .bo(bo), .out_valid(out_valid), .level(level)
`ifdef CONTRAST_CLIP_CNT_EN
    , .clip_count(clip_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] pix;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   m_pend = 8;
  int   m_level = 8;
  int   m_frame_clip = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Contrast formula from plain integer arithmetic: floor((x-128)*lvl/8)+128, clamped.
  function automatic int ref_chan(input int x, input int lvl, output bit clipped);
    int v, s, y;
    v = (x - 128) * lvl;
    if (v >= 0) s = v / 8;
    else        s = -((-v + 7) / 8);
    y = s + 128;
    clipped = (y < 0) || (y > 255);
    if (y < 0) y = 0;
    else if (y > 255) y = 255;
    return y;
  endfunction

  task automatic push_exp(input logic [23:0] px);
    exp_t e;
    bit c0, c1, c2;
    int r, g, b;
    r = ref_chan(int'(px[23:16]), m_level, c0);
    g = ref_chan(int'(px[15:8]),  m_level, c1);
    b = ref_chan(int'(px[7:0]),   m_level, c2);
    e.pix = {8'(r), 8'(g), 8'(b)};
    e.cyc = cyc;
    if (c0 || c1 || c2) m_frame_clip++;
    sb.push_back(e);
  endtask

  // Monitor: every valid output pops the oldest expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got out_valid=1 with pixel %06h, expected no output", {ro, go, bo});
      end else begin
        mon_e = sb.pop_front();
        check("pixel", int'({ro, go, bo}), int'(mon_e.pix));
        check("latency", cyc - mon_e.cyc, 2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [23:0] px);
    tick();
    in_valid = 1'b1;
    {ri, gi, bi} = px;
    push_exp(px);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      in_valid = 1'b0;
      {ri, gi, bi} = 24'($urandom);
    end
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else drive(24'($urandom));
    end
    idle(4);
  endtask

  task automatic press(input bit up, input bit dn);
    tick();
    ctrl = {~up, ~dn};
    repeat (4) tick();
    ctrl = 2'b11;
    repeat (4) tick();
    if (up && !dn && m_pend < 15) m_pend++;
    else if (dn && !up && m_pend > 0) m_pend--;
  endtask

  task automatic frame_start();
    tick();
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (2) tick();
    m_level = m_pend;
    check("level", int'(level), m_level);
`ifdef CONTRAST_CLIP_CNT_EN
    check("clip_count", int'(clip_count), m_frame_clip);
    m_frame_clip = 0;
`endif
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    in_valid = 1'b0;
    ctrl = 2'b11;
    vsync = 1'b0;
    @(negedge clk);
    #1;
    sb.delete();
    tick();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_pixel", int'({ro, go, bo}), 0);
    check("rst_level", int'(level), 8);
`ifdef CONTRAST_CLIP_CNT_EN
    check("rst_clip_count", int'(clip_count), 0);
`endif
    tick();
    reset = 1'b0;
    m_pend = 8;
    m_level = 8;
    m_frame_clip = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    // Identity at the default level.
    drive(24'hC83280);
    idle(1);
    stream(20);

    // Seven up presses then frame start: maximum level with clamping.
    repeat (7) press(1'b1, 1'b0);
    check("level_before_vsync", int'(level), 8);
    frame_start();
    drive(24'hC83280);
    idle(1);
    stream(20);

    // Saturation at the top: extra presses must not wrap.
    repeat (20) press(1'b1, 1'b0);
    frame_start();

    // Simultaneous presses leave the pending level unchanged.
    repeat (3) press(1'b0, 1'b1);
    press(1'b1, 1'b1);
    frame_start();
    stream(10);

    // Reset while outputs are flowing.
    for (int i = 0; i < 6; i++) drive(24'($urandom));
    check("pre_reset_out_valid", int'(out_valid), 1);
    do_reset();
    drive(24'h10F080);
    drive(24'($urandom));
    idle(4);

    // Frame hold: level unchanged until frame start, then level 0 -> mid-grey.
    repeat (8) press(1'b0, 1'b1);
    check("level_hold", int'(level), 8);
    drive(24'hC83280);
    stream(10);
    frame_start();
    drive(24'hFF0011);
    stream(10);

    // Randomized mix of key presses, frame starts and pixel bursts.
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 3))
        0: press(1'b1, 1'b0);
        1: press(1'b0, 1'b1);
        2: frame_start();
        default: stream($urandom_range(1, 8));
      endcase
    end

`ifdef CONTRAST_CLIP_CNT_EN
    // Clip counting at level 15: 4 clipping pixels out of 10, then a clean frame.
    do_reset();
    repeat (7) press(1'b1, 1'b0);
    frame_start();
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 0 && i < 10) drive(24'hC83280);
      else drive({8'($urandom_range(100, 156)), 8'($urandom_range(100, 156)), 8'($urandom_range(100, 156))});
    end
    idle(4);
    check("clip_frame_model", m_frame_clip, 4);
    frame_start();
    for (int i = 0; i < 10; i++)
      drive({8'($urandom_range(100, 156)), 8'($urandom_range(100, 156)), 8'($urandom_range(100, 156))});
    idle(4);
    frame_start();
`endif

    idle(4);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/contrast_adjust.md
CONTRAST_ADJUST -- requirements
Module: contrast_adjust

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 clk  input  1  pixel clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ri, gi, bi  input  8 each  pixel from the brightness stage, unsigned.
REQ-005 in_valid  input  1  pixel qualifier for ri/gi/bi.
REQ-006 vsync  input  1  frame sync, active-high; its rising edge marks frame start.
REQ-007 ctrl  input  2  raw push-keys, active-low: ctrl[1] = contrast up, ctrl[0] = contrast down.
REQ-008 ro, go, bo  output  8 each  contrast-adjusted pixel, registered.
REQ-009 out_valid  output  1  qualifier for ro/go/bo, registered.
REQ-010 level  output  4  active contrast level, registered.
REQ-011 clip_count  output  16  clipped-pixel count of the previous frame; present only with CONTRAST_CLIP_CNT_EN.

Function
REQ-012 Each ctrl bit SHALL pass through a 2-flop synchroniser. A key press event SHALL be a 1-cycle pulse on the synchronised 1->0 transition.
REQ-013 pend_level SHALL increment on an up event and decrement on a down event. It SHALL saturate at 15 and 0.
REQ-014 Simultaneous up and down events in the same cycle SHALL leave pend_level unchanged.
REQ-015 The active level SHALL load pend_level only in the cycle after a vsync rising edge, so it never changes mid-frame.
REQ-016 Per channel: d = in - 128 (signed 9-bit); p = d * level (signed 13-bit); s = p >>> 3 (arithmetic shift); y = s + 128; out = clamp(y, 0, 255).
REQ-017 Level 8 SHALL be an exact identity; level 0 SHALL output 128 for every input.
REQ-018 Pipeline latency SHALL be exactly 2 cycles: stage 1 registers the products, stage 2 registers the clamped result. out_valid SHALL equal in_valid delayed by 2 cycles.
REQ-019 The pipeline SHALL advance every cycle regardless of in_valid; there is no backpressure.
REQ-020 When out_valid is 0, the values on ro/go/bo are don't-care.
REQ-021 A level load SHALL affect only pixels entering stage 1 on or after the load cycle.

Reset
REQ-022 On reset, ro/go/bo SHALL be 0, out_valid 0, level 8, pend_level 8, synchronisers 1 (released), and clip_count 0.
REQ-023 Reset asserted mid-frame SHALL discard both pipeline stages. The first out_valid after reset SHALL be 2 cycles after the first post-reset in_valid.

Configuration
REQ-024 Macro CONTRAST_CLIP_CNT_EN defined: the block SHALL add clip_count and an internal 16-bit counter. The counter increments on each stage-2 valid pixel where any channel clamped, saturates at 0xFFFF, and on a vsync rising edge is copied to clip_count and then cleared. A pixel clamped in that same cycle SHALL count toward the new frame.
REQ-025 Macro undefined: the clip_count port and the counter logic SHALL be absent. All other behaviour is unchanged.

Structure
REQ-026 Package contrast_pkg SHALL hold LEVEL_DEFAULT=8, LEVEL_MAX=15, MID=128, SHIFT=3, and the 9/13-bit signed width constants.
REQ-027 One sub-module, key_edge, SHALL implement the synchroniser and falling-edge pulse. It SHALL be instantiated twice.
REQ-028 The per-channel arithmetic SHALL be a shared function in contrast_pkg, not a separate module.

Verification
REQ-029 Identity: after reset, drive in_valid=1 with ri/gi/bi=200/50/128 -> 2 cycles later ro/go/bo=200/50/128 and out_valid=1.
REQ-030 Max level: 7 up presses, then a vsync rise -> level=15; input 200/50/128 -> output 255/0/128 (clamped).
REQ-031 Frame hold: 8 down presses with no vsync -> level stays 8 and outputs are unchanged. After a vsync rise -> level=0 and every output = 128.
REQ-032 Simultaneous/saturation: both keys pulled low in the same cycle -> pend_level unchanged; 20 up presses -> pend_level=15, with no wrap.
REQ-033 Reset mid-stream: reset asserted while out_valid=1 -> next cycle out_valid=0, ro/go/bo=0, level=8; first valid output appears 2 cycles after in_valid resumes.
REQ-034 With CONTRAST_CLIP_CNT_EN and level=15: a frame of 10 valid pixels, 4 of which clip -> at the next vsync rise clip_count=4; a following frame with no clips -> clip_count=0.
